// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4-channel serial TDM link. Locks to fsync, tracks the
// slot index, deserialises each WIDTH-bit slot (MSB first) and publishes the
// completed word on the matching channel output.
module tdm_demux_4ch #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             sdata,
   input  logic             fsync,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic             s1,
   output logic             s0,
   output logic             slot_valid,
   output logic [1:0]       slot_idx,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] OneBit  = CntW'(1);

   typedef enum logic [0:0] {StHunt, StRecv} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q [4];
   logic [WIDTH-1:0] word_d [4];
   logic             sv_q, sv_d;
   logic [1:0]       idx_q, idx_d;
   logic             fv_q, fv_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] first_bit;
   logic             frame_start;

   assign shifted   = {shift_q[WIDTH-2:0], sdata};
   assign first_bit = {{(WIDTH-1){1'b0}}, sdata};
   // cnt=0 with slot=0 only occurs in RECV right after slot 3 has completed
   assign frame_start = (cnt_q == '0) && (slot_q == 2'd0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHunt;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered pulse outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         slot_q  <= '0;
         shift_q <= '0;
         for (int i = 0; i < 4; i++) word_q[i] <= '0;
         sv_q    <= 1'b0;
         idx_q   <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         shift_q <= shift_d;
         for (int i = 0; i < 4; i++) word_q[i] <= word_d[i];
         sv_q    <= sv_d;
         idx_q   <= idx_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
      end
   end

   // Next-state: framing checks, bit counting and slot capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      slot_d  = slot_q;
      shift_d = shift_q;
      for (int i = 0; i < 4; i++) word_d[i] = word_q[i];
      sv_d    = 1'b0;
      idx_d   = idx_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;
      if (bit_en) begin
         case (state_q)
            StHunt: begin
               if (fsync) begin
                  state_d = StRecv;
                  shift_d = first_bit;
                  cnt_d   = OneBit;
                  slot_d  = 2'd0;
               end
            end
            StRecv: begin
               if (frame_start) begin
                  if (fsync) begin
                     shift_d = first_bit;
                     cnt_d   = OneBit;
                  end else begin
                     // Lost alignment: drop this bit and hunt again
                     err_d   = 1'b1;
                     state_d = StHunt;
                     shift_d = '0;
                     cnt_d   = '0;
                  end
               end else if (fsync) begin
                  // Early fsync: abandon partial slot, restart at slot 0 bit 0
                  err_d   = 1'b1;
                  shift_d = first_bit;
                  cnt_d   = OneBit;
                  slot_d  = 2'd0;
               end else begin
                  shift_d = shifted;
                  if (cnt_q == LastBit) begin
                     word_d[slot_q] = shifted;
                     sv_d           = 1'b1;
                     idx_d          = slot_q;
                     fv_d           = (slot_q == 2'd3);
                     cnt_d          = '0;
                     slot_d         = slot_q + 2'd1;
                  end else begin
                     cnt_d = cnt_q + OneBit;
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   // Outputs
   always_comb begin
      locked      = (state_q == StRecv);
      s1          = slot_q[1];
      s0          = slot_q[0];
      d0          = word_q[0];
      d1          = word_q[1];
      d2          = word_q[2];
      d3          = word_q[3];
      slot_valid  = sv_q;
      slot_idx    = idx_q;
      frame_valid = fv_q;
      sync_err    = err_q;
   end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive end of the 4-to-1 serial time-division link: the transmit side selects channels d0..d3 in turn with s1/s0 and serialises each word; this block rebuilds the four channel words.
- Frame layout: fsync marks bit 0 of slot 0. Four slots follow, one per channel, each WIDTH bits, MSB first.
- The block locks to fsync, tracks the slot index (s1,s0), shifts each slot into a register and publishes the word to d0..d3.
- Sits between the serial line interface and the channel consumers.

Parameters:
- WIDTH, 8, bits per slot (2..32).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  sample strobe; sdata/fsync are evaluated only in cycles with bit_en=1.
- sdata  in  1  serial data bit.
- fsync  in  1  frame sync, high on first bit of slot 0.
- d0, d1, d2, d3  out  WIDTH  last complete word received for channel 0..3.
- s1, s0  out  1 each  index of the slot currently being received; channel = 2*s1+s0.
- slot_valid  out  1  one-cycle pulse; a channel word was just updated.
- slot_idx  out  2  channel updated with slot_valid.
- frame_valid  out  1  one-cycle pulse; slot 3 completed a full aligned frame.
- locked  out  1  high while in RECV.
- sync_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, sync release):
  - d0..d3=0, s1=s0=0, slot_idx=0.
  - slot_valid, frame_valid, sync_err, locked = 0.
  - State HUNT; bit counter and shift register = 0.
- Sampling: a "bit" is any cycle with bit_en=1. With bit_en=0, state, counters and shift register hold and all pulse outputs are 0.
- State HUNT:
  - sdata ignored while fsync=0.
  - A bit with fsync=1 loads sdata as bit 0 of slot 0, sets bit_cnt=1, s1s0=00, and moves to RECV.
  - locked=1 from the following cycle.
- State RECV:
  - Each bit: shift_reg <= {shift_reg[WIDTH-2:0], sdata}; bit_cnt increments.
  - Bit WIDTH-1 of a slot (slot end):
    - d[s1s0] <= {shift_reg[WIDTH-2:0], sdata}.
    - slot_valid=1 and slot_idx=s1s0 in the next cycle (one cycle after the clock edge that sampled the last bit).
    - bit_cnt <= 0; s1s0 increments, wrapping 11 -> 00.
  - End of slot 3: frame_valid=1 in the same cycle as that slot_valid. The next bit is the expected frame start.
- fsync checks in RECV:
  - fsync=1 at the expected frame start: normal; continue.
  - fsync=0 at the expected frame start:
    - sync_err pulse; go to HUNT; locked=0.
    - That bit is discarded. d0..d3 keep their values.
  - fsync=1 at any other bit (mid-frame):
    - sync_err pulse; partial slot discarded; no slot_valid.
    - Realign: this bit becomes bit 0 of slot 0 (bit_cnt=1, s1s0=00); stay in RECV.
    - Words already completed in the aborted frame remain in d*. frame_valid is not asserted for the aborted frame.
- Outputs d0..d3 change only on a slot end. Each holds until its next update.
- Pulse outputs are registered and high for exactly one clk cycle, regardless of bit_en in the following cycle.
- Reset mid-frame: immediate return to reset values. Partial data is lost.
- Throughput: one bit per clock is supported (bit_en tied high). A frame is 4*WIDTH bits.

Test Plan (WIDTH=8, bit_en=1 unless stated):
- Aligned frame: fsync on first bit; words A5,3C,0F,81 serialised MSB first.
  - slot_valid pulses for slot_idx 0,1,2,3, each 1 cycle after bits 7, 15, 23 and 31.
  - d0=A5, d1=3C, d2=0F, d3=81.
  - frame_valid with the 4th slot_valid; s1s0 returns to 00.
- Back-to-back frames: second frame 11,22,33,44 with fsync on bit 32.
  - No sync_err.
  - d* update per slot, e.g. d0=11 while d1 still 3C until its slot ends.
- Missing fsync: second frame sent with fsync=0 at bit 32.
  - sync_err pulse, locked=0.
  - d* remain A5,3C,0F,81.
  - Bits ignored until the next fsync, then relock and capture correctly.
- Mid-frame fsync: fsync at bit 12 of a frame.
  - sync_err pulse; d0 updated from slot 0; no update for slot 1.
  - Slot 0 restarts at bit 12; a new aligned frame from there decodes correctly.
- bit_en gating: bit_en=1 every 3rd cycle with the frame A5,3C,0F,81.
  - Same d* values.
  - slot_valid pulses 1 cycle wide, spaced 24 clocks apart.
- Async reset asserted mid-slot 2 and released:
  - All outputs 0 immediately on assertion.
  - HUNT on release; a subsequent aligned frame decodes correctly.
